// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with valid/ready handshake on both sides
//   clk, rst         rising-edge clock, synchronous active-high reset
//   valid_i, ready_o request handshake; ready_o is high only while idle
//   op_i             funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   a_in, b_in       rs1 / rs2 operands, sampled only in the accept cycle
//   valid_o, ready_i result handshake; valid_o holds until ready_i
//   result_o         result word, stable while valid_o and kept after the handshake
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_in,
    input  logic [XLEN-1:0] b_in,
    output logic            ready_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t          r_state;
    logic [2:0]      r_op;
    logic            r_neg;
    logic            r_bzero;
    logic [XLEN-1:0] r_m;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] r_result;
    logic [CW-1:0]   r_cnt;
    logic            r_valid;
    logic            r_ready;

    logic              w_accept;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_n;
    logic [XLEN-1:0]   w_quo_n;
    logic [XLEN-1:0]   w_rem_n;
    logic [XLEN-1:0]   w_word;

    always_comb begin
        w_accept = valid_i & r_ready;
        // a is signed for MUL/MULH/MULHSU/DIV/REM, b for MUL/MULH/DIV/REM
        w_sa     = a_in[XLEN-1] & (op_i[2] ? !op_i[0] : (op_i != 3'd3));
        w_sb     = b_in[XLEN-1] & (op_i[2] ? !op_i[0] : !op_i[1]);
        w_a_abs  = w_sa ? -a_in : a_in;
        w_b_abs  = w_sb ? -b_in : b_in;
        // shift-add step: {r_hi, r_lo} holds the running product, r_lo starts as the multiplier
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
        // restoring divide step: r_hi is the partial remainder, r_lo shifts dividend out and quotient in
        w_shift  = {r_hi, r_lo[XLEN-1]};
        w_ge     = w_shift >= {1'b0, r_m};
        w_sub    = w_shift[XLEN-1:0] - r_m;
        w_prod   = {r_hi, r_lo};
        w_prod_n = r_neg ? -w_prod : w_prod;
        // a zero divisor leaves an all-ones quotient that must not be negated
        w_quo_n  = (r_neg & !r_bzero) ? -r_lo : r_lo;
        w_rem_n  = r_neg ? -r_hi : r_hi;
        w_word   = r_op[2] ? (r_op[1] ? w_rem_n : w_quo_n)
                           : ((r_op[1:0] == 2'd0) ? w_prod_n[XLEN-1:0] : w_prod_n[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_bzero  <= 1'b0;
            r_m      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_fix    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= op_i;
                        // remainder follows the dividend; products and quotients use sa^sb
                        r_neg   <= (op_i[2] & op_i[1]) ? w_sa : (w_sa ^ w_sb);
                        r_bzero <= (b_in == '0);
                        r_m     <= op_i[2] ? w_b_abs : w_a_abs;
                        r_lo    <= op_i[2] ? w_a_abs : w_b_abs;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_op[2]) begin
                        r_hi <= w_ge ? w_sub : w_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN - 1))
                        r_state <= FIXUP;
                end
                FIXUP: begin
                    r_fix   <= w_word;
                    r_state <= DONE;
                end
                DONE: begin
                    // first DONE cycle publishes the result; later cycles wait for the consumer
                    if (!r_valid) begin
                        r_result <= r_fix;
                        r_valid  <= 1'b1;
                    end else if (ready_i) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign result_o = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] result_o;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .a_in(a_in), .b_in(b_in),
        .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r = 32'd0;
        case (op)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: r = (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
            default: r = (b == 0) ? a : 32'(ua % ub);
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // issue one op, check latency/result, hold ready_i low for 'hold' cycles, then complete the handshake
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold, input bit busy);
        logic [31:0] exp;
        int n;
        exp = model(op, a, b);
        @(negedge clk);
        chk("ready_before", ready_o, 1);
        valid_i = 1'b1; op_i = op; a_in = a; b_in = b; ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0; op_i = 3'($urandom); a_in = $urandom; b_in = $urandom;
        chk("ready_busy", ready_o, 0);
        n = 0;
        while (!valid_o && n < 60) begin
            @(negedge clk);
            n++;
            if (busy && n == 5) begin
                valid_i = 1'b1; op_i = 3'($urandom); a_in = $urandom; b_in = $urandom;
            end else
                valid_i = 1'b0;
        end
        chk("latency", n, 34);
        chk($sformatf("result op%0d a=%h b=%h", op, a, b), result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_result", result_o, exp);
            chk("hold_valid", valid_o, 1);
            chk("hold_ready", ready_o, 0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        chk("post_valid", valid_o, 0);
        chk("post_ready", ready_o, 1);
        chk("post_result", result_o, exp);
    endtask

    initial begin
        int n;
        int seen;
        logic [31:0] a, b;
        logic [2:0] op;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        rst = 1'b0;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
        do_op(3'd5, 32'hFFFF_FFFF, 32'd2, 0, 0);
        do_op(3'd7, 32'd10, 32'd3, 0, 0);
        do_op(3'd4, 32'd5, 32'd0, 0, 0);
        do_op(3'd7, 32'd5, 32'd0, 0, 0);
        do_op(3'd6, 32'hFFFF_FFFB, 32'd0, 0, 0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, 0);
        do_op(3'd4, 32'd100, 32'd7, 2, 1);

        // reset in the middle of a calculation discards the op
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd0; a_in = 32'd3; b_in = 32'd4;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", ready_o, 1);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_result", result_o, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        chk("midrst_no_valid", seen, 0);
        do_op(3'd5, 32'd1000, 32'd9, 0, 0);

        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom);
            n = $urandom_range(0, 7);
            a = (n == 0) ? 32'h8000_0000 : $urandom;
            b = (n == 1) ? 32'd0 : (n == 2) ? 32'hFFFF_FFFF : (n == 3) ? 32'($urandom_range(1, 15)) : $urandom;
            do_op(op, a, b, $urandom_range(0, 2), k % 5 == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
